// File: rtl/mux64_pkg.sv
// Shared types and helpers for the 64-requester round-robin arbiter.
// The state enum, request vector and index types are used by the arbiter and its picker.
package mux64_pkg;

   localparam int unsigned N_REQ = 64;
   localparam int unsigned IDX_W = 6;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   typedef logic [N_REQ-1:0] req_vec_t;
   typedef logic [IDX_W-1:0] idx_t;

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic idx_t lowest_set(input req_vec_t v);
      idx_t r;
      r = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (v[i]) begin
            r = idx_t'(i);
         end
      end
      return r;
   endfunction

   function automatic req_vec_t idx_to_onehot(input idx_t i);
      return req_vec_t'(1) << i;
   endfunction

endpackage

// File: rtl/rr_pick64.sv
// Combinational circular priority encoder: first set request at or above ptr,
// wrapping to the lowest set request when nothing at or above ptr is requesting.
module rr_pick64
   import mux64_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] idx
);

   req_vec_t mask;
   req_vec_t masked;

   always_comb begin
      mask   = {N_REQ{1'b1}} << ptr;
      masked = req & mask;
      any    = |req;
      idx    = (|masked) ? lowest_set(masked) : lowest_set(req);
   end

endmodule

// File: rtl/mux64_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 64:1 mux, with a bounded hold time.
// All outputs are registered; grant_idx holds its last value while idle.
module mux64_rr_arbiter
   import mux64_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             release_i,
   output logic             grant_valid,
   output logic [IDX_W-1:0] grant_idx,
   output logic [N_REQ-1:0] grant_onehot,
   output logic             timeout_o
);

   localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   arb_state_t       state_q, state_d;
   idx_t             ptr_q, ptr_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             grant_valid_d;
   idx_t             grant_idx_d;
   req_vec_t         grant_onehot_d;
   logic             timeout_d;

   logic             pick_any;
   idx_t             pick_idx;
   logic             end_rel, end_drop, end_time;

   rr_pick64 u_pick (
      .req (req),
      .ptr (ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   always_comb begin
      state_d        = state_q;
      ptr_d          = ptr_q;
      hold_cnt_d     = hold_cnt_q;
      grant_valid_d  = grant_valid;
      grant_idx_d    = grant_idx;
      grant_onehot_d = grant_onehot;
      timeout_d      = 1'b0;
      end_rel        = 1'b0;
      end_drop       = 1'b0;
      end_time       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d        = GRANT;
               grant_valid_d  = 1'b1;
               grant_idx_d    = pick_idx;
               grant_onehot_d = idx_to_onehot(pick_idx);
               hold_cnt_d     = '0;
            end
         end
         GRANT: begin
            end_rel  = release_i;
            end_drop = ~req[grant_idx];
            end_time = (hold_cnt_q == HOLD_LAST);
            if (end_rel || end_drop || end_time) begin
               state_d        = IDLE;
               grant_valid_d  = 1'b0;
               grant_onehot_d = '0;
               ptr_d          = grant_idx + 1'b1;
               // A timeout is only reported when the timer alone ended the grant.
               timeout_d      = end_time & ~end_rel & ~end_drop;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         hold_cnt_q   <= '0;
         grant_valid  <= 1'b0;
         grant_idx    <= '0;
         grant_onehot <= '0;
         timeout_o    <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         hold_cnt_q   <= hold_cnt_d;
         grant_valid  <= grant_valid_d;
         grant_idx    <= grant_idx_d;
         grant_onehot <= grant_onehot_d;
         timeout_o    <= timeout_d;
      end
   end

`ifndef SYNTHESIS
   a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      grant_onehot == (grant_valid ? idx_to_onehot(grant_idx) : '0));
   a_timeout_idle: assert property (@(posedge clk) disable iff (!rst_n)
      timeout_o |-> !grant_valid);
   a_hold_bound: assert property (@(posedge clk) disable iff (!rst_n)
      32'(hold_cnt_q) < MAX_HOLD);
`endif

endmodule

// File: tb/tb_mux64_rr_arbiter.sv
// Directed bench for mux64_rr_arbiter: a grant-age model is checked every cycle,
// and literal expectations pin grant order, timeout length and async reset behaviour.
module tb_mux64_rr_arbiter;

   localparam int MAX_HOLD = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [63:0] req = '0;
   logic        release_i = 1'b0;
   logic        grant_valid;
   logic [5:0]  grant_idx;
   logic [63:0] grant_onehot;
   logic        timeout_o;

   int checks = 0;
   int failures = 0;

   // Model state: who holds the grant, how many cycles it has been held, rotation start.
   bit m_valid = 1'b0;
   int m_idx = 0;
   int m_ptr = 0;
   int m_age = 0;
   bit m_to = 1'b0;

   mux64_rr_arbiter #(
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .release_i    (release_i),
      .grant_valid  (grant_valid),
      .grant_idx    (grant_idx),
      .grant_onehot (grant_onehot),
      .timeout_o    (timeout_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic int rr_pick(input logic [63:0] r, input int p);
      for (int k = 0; k < 64; k++) begin
         if (r[(p + k) % 64]) return (p + k) % 64;
      end
      return -1;
   endfunction

   function automatic logic [63:0] one(input int a);
      return 64'd1 << a;
   endfunction

   function automatic logic [63:0] two(input int a, input int b);
      return (64'd1 << a) | (64'd1 << b);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int j;
      if (!rst_n) begin
         m_valid = 1'b0;
         m_idx   = 0;
         m_ptr   = 0;
         m_age   = 0;
         m_to    = 1'b0;
      end else begin
         m_to = 1'b0;
         if (!m_valid) begin
            j = rr_pick(req, m_ptr);
            if (j >= 0) begin
               m_valid = 1'b1;
               m_idx   = j;
               m_age   = 1;
            end
         end else if (release_i || !req[m_idx] || m_age == MAX_HOLD) begin
            m_to    = (m_age == MAX_HOLD) && !release_i && req[m_idx];
            m_valid = 1'b0;
            m_ptr   = (m_idx + 1) % 64;
         end else begin
            m_age++;
         end
      end
   end

   always @(negedge clk) begin
      check("cyc_valid", 64'(grant_valid), 64'(m_valid));
      check("cyc_idx", 64'(grant_idx), 64'(m_idx));
      check("cyc_onehot", grant_onehot, m_valid ? one(m_idx) : 64'd0);
      check("cyc_timeout", 64'(timeout_o), 64'(m_to));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // End the current grant by release (with a new request pattern), then take the next grant.
   task automatic rel_next(input logic [63:0] r, input int exp, input string name);
      req = r;
      release_i = 1'b1;
      tick();
      release_i = 1'b0;
      check({name, "_gap"}, 64'(grant_valid), 64'd0);
      tick();
      check({name, "_valid"}, 64'(grant_valid), 64'd1);
      check({name, "_idx"}, 64'(grant_idx), 64'(exp));
   endtask

   initial begin
      int len;
      bit done;

      req = '1;
      #1 rst_n = 1'b0;
      repeat (3) tick();
      check("rst_valid", 64'(grant_valid), 64'd0);
      check("rst_idx", 64'(grant_idx), 64'd0);
      check("rst_onehot", grant_onehot, 64'd0);
      check("rst_timeout", 64'(timeout_o), 64'd0);
      #2 rst_n = 1'b1;
      tick();
      check("first_valid", 64'(grant_valid), 64'd1);
      check("first_idx", 64'(grant_idx), 64'd0);

      rel_next(two(5, 40), 5, "rr_a");
      rel_next(two(5, 40), 40, "rr_b");
      rel_next(two(5, 40), 5, "rr_c");

      rel_next(one(62), 62, "wrap_setup");
      rel_next(two(0, 63), 63, "wrap_a");
      rel_next(two(0, 63), 0, "wrap_b");
      rel_next(two(0, 63), 63, "wrap_c");

      rel_next(two(3, 9), 3, "to_start");
      len = 1;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         tick();
         if (grant_valid) len++;
         else done = 1'b1;
      end
      check("to_ended", 64'(done), 64'd1);
      check("to_len", 64'(len), 64'd16);
      check("to_pulse", 64'(timeout_o), 64'd1);
      tick();
      check("to_once", 64'(timeout_o), 64'd0);
      check("to_next_valid", 64'(grant_valid), 64'd1);
      check("to_next_idx", 64'(grant_idx), 64'd9);

      repeat (15) tick();
      check("sim_held", 64'(grant_valid), 64'd1);
      release_i = 1'b1;
      tick();
      release_i = 1'b0;
      check("sim_end", 64'(grant_valid), 64'd0);
      check("sim_no_to", 64'(timeout_o), 64'd0);
      tick();
      check("sim_next_idx", 64'(grant_idx), 64'd3);

      rel_next(two(7, 12), 7, "drop_start");
      req = one(12);
      tick();
      check("drop_end", 64'(grant_valid), 64'd0);
      check("drop_no_to", 64'(timeout_o), 64'd0);
      tick();
      check("drop_next_valid", 64'(grant_valid), 64'd1);
      check("drop_next_idx", 64'(grant_idx), 64'd12);

      rel_next(one(63), 63, "fair_setup");
      rel_next('1, 0, "fair_0");
      for (int k = 1; k <= 64; k++) rel_next('1, k % 64, "fair");
      for (int k = 1; k <= 20; k++) rel_next('1, k, "pre_rst");

      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 64'(grant_valid), 64'd0);
      check("arst_onehot", grant_onehot, 64'd0);
      check("arst_idx", 64'(grant_idx), 64'd0);
      repeat (2) tick();
      #2 rst_n = 1'b1;
      tick();
      check("arst_first_valid", 64'(grant_valid), 64'd1);
      check("arst_first_idx", 64'(grant_idx), 64'd0);

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
